// File: rtl/imgproc_pkg.sv
// Shared definitions for the 3x3 image filter: mode encoding, kernel tables
// and pipeline latency.
package imgproc_pkg;

  typedef enum logic [1:0] {
    MODE_PASS     = 2'd0,
    MODE_GAUSS    = 2'd1,
    MODE_SOBELX   = 2'd2,
    MODE_SOBELMAG = 2'd3
  } mode_e;

  localparam int FILT_LAT    = 3;
  localparam int GAUSS_SHIFT = 4;
  localparam int KERN_N      = 9;

  // Row-major, row 0 is the oldest line (y-2), column 0 the oldest pixel (x-2).
  localparam int K_GAUSS [KERN_N] = '{ 1,  2,  1,  2, 4, 2,  1, 2, 1};
  localparam int K_GX    [KERN_N] = '{-1,  0,  1, -2, 0, 2, -1, 0, 1};
  localparam int K_GY    [KERN_N] = '{-1, -2, -1,  0, 0, 0,  1, 2, 1};

  function automatic int kidx(input int row, input int col);
    return row * 3 + col;
  endfunction

endpackage

// File: rtl/linebuf_2row.sv
// Two-row line buffer: row y is written into bank y[0] while both banks are
// read at the same column, giving rows y-1 and y-2 one cycle later.
module linebuf_2row #(
  parameter int  DATA_W = 12,
  parameter int  IMG_W  = 640,
  localparam int AW     = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
  input  logic              clk,
  input  logic              en,
  input  logic              row_sel,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rd_prev1,
  output logic [DATA_W-1:0] rd_prev2
);

  logic [1:0][DATA_W-1:0] rd_bank;
  logic                   row_sel_q;

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic [DATA_W-1:0] mem [IMG_W];
    logic [DATA_W-1:0] rd_q;

    // Read-first: the bank being overwritten still yields row y-2.
    always_ff @(posedge clk) begin
      if (en) begin
        if (row_sel == 1'(gi)) begin
          mem[addr] <= wdata;
        end
        rd_q <= mem[addr];
      end
    end

    assign rd_bank[gi] = rd_q;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      row_sel_q <= row_sel;
    end
  end

  assign rd_prev1 = row_sel_q ? rd_bank[0] : rd_bank[1];
  assign rd_prev2 = row_sel_q ? rd_bank[1] : rd_bank[0];

endmodule

// File: rtl/imgproc_filter3x3.sv
// Streaming 3x3 filter (pass / Gaussian / Sobel-X / Sobel magnitude) with a
// fixed three-cycle latency from input beat to oDVAL.
module imgproc_filter3x3
  import imgproc_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int IMG_W  = 640,
  parameter int CNT_W  = 16
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iDVAL,
  input  logic [CNT_W-1:0]  iX_Cont,
  input  logic [CNT_W-1:0]  iY_Cont,
  input  logic [1:0]        iMODE,
  output logic [DATA_W-1:0] oRed,
  output logic [DATA_W-1:0] oGreen,
  output logic [DATA_W-1:0] oBlue,
  output logic              oDVAL,
  output logic [1:0]        oMODE
);

  localparam int ACC_W = DATA_W + 5;
  localparam int AW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [CNT_W-1:0] IMG_W_C = CNT_W'(IMG_W);
  localparam logic [CNT_W-1:0] TWO_C   = CNT_W'(2);
  localparam logic [ACC_W:0]   SAT_MAX = {{(ACC_W + 1 - DATA_W){1'b0}}, {DATA_W{1'b1}}};

  logic                         in_range, frame_start, zero_in, lb_en;
  logic [AW-1:0]                lb_addr;
  logic [DATA_W-1:0]            lb_prev1, lb_prev2;

  logic [FILT_LAT-1:0]          vld_d, vld_q;
  mode_e                        mode_d, mode_q;
  mode_e                        s1_mode_d, s1_mode_q, s2_mode_d, s2_mode_q;
  logic                         s1_zero_d, s1_zero_q, s2_zero_d, s2_zero_q;
  logic [DATA_W-1:0]            pix_d, pix_q, out_d, out_q;
  logic [2:0][DATA_W-1:0]       col_a_d, col_a_q, col_b_d, col_b_q, col_cur;
  logic [KERN_N-1:0][DATA_W-1:0] win;
  logic signed [ACC_W-1:0]      acc_a_d, acc_a_q, acc_b_d, acc_b_q;
  logic signed [ACC_W-1:0]      pix_s, gauss_sum, gx_sum, gy_sum;
  logic [ACC_W-1:0]             abs_a, abs_b;
  logic [ACC_W:0]               res;
  logic [DATA_W-1:0]            sat;

  assign in_range    = iX_Cont < IMG_W_C;
  assign frame_start = iDVAL && (iX_Cont == '0) && (iY_Cont == '0);
  assign zero_in     = !in_range || (iX_Cont < TWO_C) || (iY_Cont < TWO_C);
  assign lb_en       = iDVAL && in_range;
  assign lb_addr     = iX_Cont[AW-1:0];

  linebuf_2row #(
    .DATA_W (DATA_W),
    .IMG_W  (IMG_W)
  ) u_linebuf (
    .clk      (iCLK),
    .en       (lb_en),
    .row_sel  (iY_Cont[0]),
    .addr     (lb_addr),
    .wdata    (iDATA),
    .rd_prev1 (lb_prev1),
    .rd_prev2 (lb_prev2)
  );

  // Newest column: the line-buffer read data lines up with the registered pixel.
  assign col_cur = {pix_q, lb_prev1, lb_prev2};

  for (genvar gi = 0; gi < 3; gi++) begin : g_win
    assign win[kidx(gi, 0)] = col_b_q[gi];
    assign win[kidx(gi, 1)] = col_a_q[gi];
    assign win[kidx(gi, 2)] = col_cur[gi];
  end

  // Stage 1: mode capture and window shift, only on input beats.
  always_comb begin
    vld_d     = {vld_q[FILT_LAT-2:0], iDVAL};
    mode_d    = mode_q;
    s1_mode_d = s1_mode_q;
    s1_zero_d = s1_zero_q;
    pix_d     = pix_q;
    col_a_d   = col_a_q;
    col_b_d   = col_b_q;
    if (frame_start) begin
      mode_d = mode_e'(iMODE);
    end
    if (iDVAL) begin
      s1_mode_d = mode_d;
      s1_zero_d = zero_in;
      pix_d     = iDATA;
      col_a_d   = col_cur;
      col_b_d   = col_a_q;
    end
  end

  // Stage 2: kernel sums over the window.
  always_comb begin
    pix_s     = '0;
    gauss_sum = '0;
    gx_sum    = '0;
    gy_sum    = '0;
    for (int i = 0; i < KERN_N; i++) begin
      pix_s     = ACC_W'(win[i]);
      gauss_sum = gauss_sum + ACC_W'(K_GAUSS[i]) * pix_s;
      gx_sum    = gx_sum    + ACC_W'(K_GX[i])    * pix_s;
      gy_sum    = gy_sum    + ACC_W'(K_GY[i])    * pix_s;
    end
    case (s1_mode_q)
      MODE_PASS:  acc_a_d = ACC_W'(win[kidx(1, 1)]);
      MODE_GAUSS: acc_a_d = gauss_sum;
      default:    acc_a_d = gx_sum;
    endcase
    acc_b_d   = gy_sum;
    s2_mode_d = s1_mode_q;
    s2_zero_d = s1_zero_q;
  end

  // Stage 3: magnitude, scaling and saturation.
  always_comb begin
    abs_a = acc_a_q[ACC_W-1] ? -acc_a_q : acc_a_q;
    abs_b = acc_b_q[ACC_W-1] ? -acc_b_q : acc_b_q;
    case (s2_mode_q)
      MODE_PASS:   res = {1'b0, acc_a_q};
      MODE_GAUSS:  res = {1'b0, acc_a_q >>> GAUSS_SHIFT};
      MODE_SOBELX: res = {1'b0, abs_a};
      default:     res = {1'b0, abs_a} + {1'b0, abs_b};
    endcase
    sat   = (res > SAT_MAX) ? {DATA_W{1'b1}} : res[DATA_W-1:0];
    out_d = out_q;
    if (vld_q[FILT_LAT-2]) begin
      out_d = s2_zero_q ? '0 : sat;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      vld_q     <= '0;
      mode_q    <= MODE_PASS;
      s1_mode_q <= MODE_PASS;
      s1_zero_q <= 1'b0;
      pix_q     <= '0;
      col_a_q   <= '0;
      col_b_q   <= '0;
      s2_mode_q <= MODE_PASS;
      s2_zero_q <= 1'b0;
      acc_a_q   <= '0;
      acc_b_q   <= '0;
      out_q     <= '0;
    end else begin
      vld_q     <= vld_d;
      mode_q    <= mode_d;
      s1_mode_q <= s1_mode_d;
      s1_zero_q <= s1_zero_d;
      pix_q     <= pix_d;
      col_a_q   <= col_a_d;
      col_b_q   <= col_b_d;
      s2_mode_q <= s2_mode_d;
      s2_zero_q <= s2_zero_d;
      acc_a_q   <= acc_a_d;
      acc_b_q   <= acc_b_d;
      out_q     <= out_d;
    end
  end

  assign oRed   = out_q;
  assign oGreen = out_q;
  assign oBlue  = out_q;
  assign oDVAL  = vld_q[FILT_LAT-1];
  assign oMODE  = mode_q;

endmodule

// File: tb/tb_imgproc_filter3x3.sv
// Bench for imgproc_filter3x3: frames driven in raster order, expected pixels
// computed from a stored copy of the frame and checked three cycles later.
module tb_imgproc_filter3x3;

  localparam int DW  = 12;
  localparam int IW  = 8;
  localparam int CW  = 16;
  localparam int LAT = 3;
  localparam int MAXV = 4095;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic [DW-1:0] i_data;
  logic          i_dval;
  logic [CW-1:0] i_x, i_y;
  logic [1:0]    i_mode;
  logic [DW-1:0] o_red, o_green, o_blue;
  logic          o_dval;
  logic [1:0]    o_mode;

  imgproc_filter3x3 #(
    .DATA_W (DW),
    .IMG_W  (IW),
    .CNT_W  (CW)
  ) dut (
    .iCLK    (clk),
    .iRST    (rst_n),
    .iDATA   (i_data),
    .iDVAL   (i_dval),
    .iX_Cont (i_x),
    .iY_Cont (i_y),
    .iMODE   (i_mode),
    .oRed    (o_red),
    .oGreen  (o_green),
    .oBlue   (o_blue),
    .oDVAL   (o_dval),
    .oMODE   (o_mode)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  int n_out    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int due;
    int val;
  } exp_t;

  exp_t q[$];
  int   img [IW][IW];
  int   mdl_mode = 0;

  function automatic int wt(input int k);
    return (k == 1) ? 2 : 1;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Filter result for the 3x3 neighbourhood centred on (x-1, y-1).
  function automatic int ref_pixel(input int x, input int y, input int m);
    int p [3][3];
    int g, gx, gy, r;
    g = 0; gx = 0; gy = 0; r = 0;
    if (x < 2 || y < 2 || x >= IW) return 0;
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 3; cc++)
        p[rr][cc] = img[y - 2 + rr][x - 2 + cc];
    for (int k = 0; k < 3; k++) begin
      gx += wt(k) * (p[k][2] - p[2 - 2][0 + 0] * 0 - p[k][0]);
      gy += wt(k) * (p[2][k] - p[0][k]);
      for (int c = 0; c < 3; c++) g += wt(k) * wt(c) * p[k][c];
    end
    case (m)
      0:       r = p[1][1];
      1:       r = g / 16;
      2:       r = iabs(gx);
      default: r = iabs(gx) + iabs(gy);
    endcase
    return (r > MAXV) ? MAXV : r;
  endfunction

  always @(negedge clk) begin
    if (o_dval) begin
      n_out++;
      if (q.size() == 0) begin
        check("spurious_dval", o_dval, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("latency_cycle", cyc, e.due);
        check("red", o_red, e.val);
        check("green", o_green, e.val);
        check("blue", o_blue, e.val);
      end
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      check("missing_dval", o_dval, 1);
      void'(q.pop_front());
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      i_dval = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_red"}, o_red, 0);
    check({tag, "_green"}, o_green, 0);
    check({tag, "_blue"}, o_blue, 0);
    check({tag, "_dval"}, o_dval, 0);
    check({tag, "_mode"}, o_mode, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_dval = 1'b0;
    #2;
    rst_n = 1'b0;
    q.delete();
    mdl_mode = 0;
    #1;
    check_reset_outputs("midreset");
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic drive_pixel(input int x, input int y, input int d, input int m, input int idle_pct);
    exp_t e;
    while ($urandom_range(99) < idle_pct) begin
      @(negedge clk);
      i_dval = 1'b0;
      i_x    = CW'($urandom_range(15));
      i_y    = CW'($urandom_range(15));
      i_data = DW'($urandom_range(MAXV));
      i_mode = 2'($urandom_range(3));
    end
    @(negedge clk);
    i_dval = 1'b1;
    i_x    = CW'(x);
    i_y    = CW'(y);
    i_data = DW'(d);
    i_mode = 2'(m);
    if (x == 0 && y == 0) mdl_mode = m;
    img[y][x] = d;
    e.due = cyc + LAT;
    e.val = ref_pixel(x, y, mdl_mode);
    q.push_back(e);
  endtask

  // kind: 0 ramp, 1 constant 100, 2 vertical step, other random.
  task automatic run_frame(input int kind, input int m0, input int m1, input int chg_x,
                           input int chg_y, input int idle_pct, input bit abort);
    int d, m;
    for (int y = 0; y < IW; y++) begin
      for (int x = 0; x < IW; x++) begin
        if (abort && x == 5 && y == 4) begin
          do_reset();
          return;
        end
        m = (y * IW + x >= chg_y * IW + chg_x) ? m1 : m0;
        case (kind)
          0:       d = x + IW * y;
          1:       d = 100;
          2:       d = (x < 4) ? 0 : 2000;
          default: d = $urandom_range(MAXV);
        endcase
        drive_pixel(x, y, d, m, idle_pct);
        if ((x == 0 && y == 0) || (x == chg_x && y == chg_y)) begin
          @(posedge clk);
          #1;
          check("omode", o_mode, mdl_mode);
        end
      end
    end
  endtask

  initial begin
    int n0, m;
    i_dval = 1'b0;
    i_data = '0;
    i_x    = '0;
    i_y    = '0;
    i_mode = '0;
    rst_n  = 1'b0;
    #3;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;

    run_frame(0, 0, 0, 0, IW, 0, 1'b0);
    idle(5);
    n0 = n_out;
    run_frame(1, 1, 1, 0, IW, 0, 1'b0);
    idle(5);
    check("pulse_count", n_out - n0, 64);
    run_frame(2, 2, 2, 0, IW, 0, 1'b0);
    run_frame(3, 1, 2, 3, 3, 0, 1'b0);
    run_frame(3, 2, 2, 0, IW, 0, 1'b0);
    run_frame(3, 3, 3, 0, IW, 30, 1'b0);
    for (int f = 0; f < 3; f++) begin
      m = $urandom_range(3);
      run_frame(3, m, m, 0, IW, 30, 1'b0);
    end
    run_frame(3, 1, 1, 0, IW, 0, 1'b1);
    run_frame(3, 3, 3, 0, IW, 20, 1'b0);
    idle(LAT + 4);
    check("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imgproc_filter3x3.md
IMGPROC_FILTER3X3 -- requirements
Module: imgproc_filter3x3

Interface
REQ-001 Parameter DATA_W, default 12: pixel width in bits.
REQ-002 Parameter IMG_W, default 640: maximum line length in pixels, which sets the line-buffer depth.
REQ-003 Parameter CNT_W, default 16: width of the column and row counters.
REQ-004 Port iCLK, input, 1: single clock; all logic is clocked on the rising edge.
REQ-005 Port iRST, input, 1: asynchronous, active-low reset.
REQ-006 Port iDATA, input, DATA_W: grayscale pixel.
REQ-007 Port iDVAL, input, 1: pixel valid, one beat per pixel; gaps of any length are allowed.
REQ-008 Port iX_Cont, input, CNT_W: column of iDATA.
REQ-009 Port iY_Cont, input, CNT_W: row of iDATA.
REQ-010 Port iMODE, input, 2: requested filter: 0 pass, 1 Gaussian, 2 Sobel-X, 3 Sobel magnitude.
REQ-011 Port oRed, oGreen, oBlue, output, DATA_W each: filtered pixel, replicated on all three.
REQ-012 Port oDVAL, output, 1: output pixel valid.
REQ-013 Port oMODE, output, 2: mode currently in effect.

Function
REQ-014 The block shall keep the two previous rows in a line buffer addressed by iX_Cont, writing only on iDVAL beats with iX_Cont < IMG_W.
REQ-015 Each iDVAL beat shall shift one column into a 3x3 window: current row plus the two buffered rows at the same column.
REQ-016 Each input beat at (x,y) shall produce exactly one oDVAL pulse exactly 3 cycles later, carrying the result for centre (x-1,y-1).
REQ-017 Cycles without iDVAL shall propagate as bubbles, so output beat count equals input beat count.
REQ-018 If x<2, y<2, or x>=IMG_W, the output value shall be 0, and oDVAL shall still pulse.
REQ-019 Mode 0 shall output the window centre pixel.
REQ-020 Mode 1 shall output the sum of kernel [1 2 1; 2 4 2; 1 2 1] over the window, shifted right by 4 and truncated.
REQ-021 Mode 2 shall output |Gx|, with Gx = kernel [-1 0 1; -2 0 2; -1 0 1] over the window.
REQ-022 Mode 3 shall output |Gx|+|Gy|, with Gy the transpose kernel of Gx.
REQ-023 Accumulation shall be signed and DATA_W+5 bits wide, with no intermediate overflow.
REQ-024 The final result shall saturate to 2^DATA_W-1.
REQ-025 The active mode shall load from iMODE only on the beat with iDVAL=1, iX_Cont=0 and iY_Cont=0.
REQ-026 A mode change mid-frame shall have no effect until the next frame start.
REQ-027 The mode shall be captured per beat at pipeline entry, so in-flight pixels finish in the mode they entered with.
REQ-028 oMODE shall show the active mode register.
REQ-029 The pipeline shall have 3 stages: window/line-buffer read, multiply-accumulate, then abs/saturate/output register.

Reset
REQ-030 While iRST=0, oRed, oGreen, oBlue, oDVAL and oMODE shall all read 0, asynchronously.
REQ-031 Reset shall clear the window and all pipeline valid bits; line-buffer contents need not be cleared.
REQ-032 Reset asserted mid-frame shall drop all in-flight beats, with no oDVAL pulse after release for any beat accepted before reset.
REQ-033 After reset release, the first beat shall be accepted on the next edge.

Structure
REQ-034 A shared package imgproc_pkg shall hold the mode enum (MODE_PASS, MODE_GAUSS, MODE_SOBELX, MODE_SOBELMAG), the kernel coefficient constants, and the latency constant FILT_LAT=3.
REQ-035 The two-row line buffer shall be a sub-module linebuf_2row, parameterised by DATA_W and IMG_W, with one write port and two read ports in the same cycle.

Verification (IMG_W=8, DATA_W=12)
REQ-036 Ramp, mode 0: pixel=x+8y over an 8x8 frame -> beat (x,y) yields x-1+8(y-1) 3 cycles later, and 0 where x<2 or y<2.
REQ-037 Constant 100, mode 1 -> interior outputs 100; border outputs 0; 64 oDVAL pulses total.
REQ-038 Vertical step, mode 2: columns 0-3=0, columns 4-7=2000 -> centres at columns 3 and 4 saturate to 4095; other interior centres output 0.
REQ-039 iMODE changed 1->2 at pixel (3,3) -> the rest of the frame stays mode 1; mode 2 applies from the next frame's (0,0), and oMODE changes on that beat.
REQ-040 Random iDVAL gaps (30% idle) -> output stream equals the gap-free reference stream, each output exactly 3 cycles after its input beat.
REQ-041 iRST pulsed low at pixel (5,4) -> outputs go 0 immediately, and no stale oDVAL pulses occur after release.
